alu_muldiv_control: RTL and testbench

Parametrised, sequential successor to the combinational ALU control decoder. It decodes `ALUOp`/`ALUFunction` into the `ALUOperation` code for the datapath ALU, adding `SLT`. It also owns an iterative unsigned multiply/divide engine with `HI`/`LO` registers (`MULTU`, `DIVU`, `MFHI`, `MFLO`). It sits in the execute stage beside the ALU and raises `Stall` to freeze instruction issue while the engine is busy.

---
 rtl/alu_muldiv_control_if.sv | 25 ++
 rtl/alu_muldiv_control.sv | 162 ++++++++++++++++
 tb/tb_alu_muldiv_control.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_control_if.sv
// Issue-side bundle between execute-stage control and the ALU control / mul-div engine.
// The master drives the decoded instruction and operands; the slave returns the ALU code, HI/LO read data and stall.
interface alu_muldiv_control_if #(
    parameter int WIDTH       = 32,
    parameter int ALUOP_WIDTH = 4
);
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic [5:0]             ALUFunction;
    logic                   Valid;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [3:0]             ALUOperation;
    logic [WIDTH-1:0]       HiLoOut;
    logic                   Stall;

    modport master (
        output ALUOp, ALUFunction, Valid, A, B,
        input  ALUOperation, HiLoOut, Stall
    );

    modport slave (
        input  ALUOp, ALUFunction, Valid, A, B,
        output ALUOperation, HiLoOut, Stall
    );
endinterface

// File: rtl/alu_muldiv_control.sv
// ALU control decoder plus iterative unsigned MULTU/DIVU engine owning HI/LO.
// A launch stalls issue for exactly WIDTH cycles; results are readable WIDTH+1 cycles after issue.
module alu_muldiv_control #(
    parameter int WIDTH       = 32,
    parameter int ALUOP_WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    alu_muldiv_control_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]          CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [ALUOP_WIDTH-1:0] OP_RTYPE = '1;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             is_rtype;
    logic             launch;
    logic [3:0]       alu_op;

    assign is_rtype = (bus.ALUOp == OP_RTYPE);
    assign launch   = (state_q == S_IDLE) && bus.Valid && is_rtype &&
                      ((bus.ALUFunction == F_MULTU) || (bus.ALUFunction == F_DIVU));

    always_comb begin
        alu_op = 4'd9;
        if (is_rtype) begin
            case (bus.ALUFunction)
                F_AND:           alu_op = 4'd0;
                F_OR:            alu_op = 4'd1;
                F_NOR:           alu_op = 4'd2;
                F_ADD:           alu_op = 4'd3;
                F_SUB:           alu_op = 4'd4;
                F_SLL:           alu_op = 4'd6;
                F_SRL:           alu_op = 4'd7;
                F_SLT:           alu_op = 4'd8;
                F_MFHI, F_MFLO:  alu_op = 4'd10;
                F_MULTU, F_DIVU: alu_op = 4'd11;
                default:         alu_op = 4'd9;
            endcase
        end else begin
            case (bus.ALUOp)
                ALUOP_WIDTH'(1): alu_op = 4'd3;
                ALUOP_WIDTH'(2): alu_op = 4'd1;
                ALUOP_WIDTH'(3): alu_op = 4'd0;
                ALUOP_WIDTH'(4): alu_op = 4'd5;
                ALUOP_WIDTH'(5): alu_op = 4'd3;
                ALUOP_WIDTH'(6): alu_op = 4'd3;
                ALUOP_WIDTH'(7): alu_op = 4'd4;
                ALUOP_WIDTH'(8): alu_op = 4'd4;
                default:         alu_op = 4'd9;
            endcase
        end
    end

    // Multiply: acc_hi:acc_lo starts as 0:A and shifts right, adding B into the top when the low bit is set.
    logic [WIDTH:0]   mul_sum;
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok    = ~div_diff[WIDTH+1];
        if (is_div_q) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d  = S_BUSY;
                    cnt_d    = CNT_LOAD;
                    is_div_d = (bus.ALUFunction == F_DIVU);
                    opb_d    = bus.B;
                    acc_hi_d = '0;
                    acc_lo_d = bus.A;
                end
            end
            S_BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.ALUOperation = alu_op;
    assign bus.Stall        = (state_q == S_BUSY);
    assign bus.HiLoOut      = (is_rtype && bus.ALUFunction == F_MFHI) ? hi_q :
                              (is_rtype && bus.ALUFunction == F_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_alu_muldiv_control.sv
// Randomized and directed bench for alu_muldiv_control at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_muldiv_control;
    localparam logic [5:0] MFHI = 6'h10, MFLO = 6'h12, MULTU = 6'h19, DIVU = 6'h1B;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_muldiv_control_if #(.WIDTH(32), .ALUOP_WIDTH(4)) b32 ();
    alu_muldiv_control_if #(.WIDTH(8),  .ALUOP_WIDTH(4)) b8 ();

    alu_muldiv_control #(.WIDTH(32), .ALUOP_WIDTH(4)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    alu_muldiv_control #(.WIDTH(8),  .ALUOP_WIDTH(4)) dut8  (.clk(clk), .reset(reset), .bus(b8));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic logic [3:0] ref_aluop(input logic [3:0] op, input logic [5:0] f);
        logic [3:0] itab [16];
        itab = '{4'd9, 4'd3, 4'd1, 4'd0, 4'd5, 4'd3, 4'd3, 4'd4,
                 4'd4, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        if (op != 4'hF) return itab[op];
        if (f == 6'h24) return 4'd0;
        if (f == 6'h25) return 4'd1;
        if (f == 6'h27) return 4'd2;
        if (f == 6'h20) return 4'd3;
        if (f == 6'h22) return 4'd4;
        if (f == 6'h00) return 4'd6;
        if (f == 6'h02) return 4'd7;
        if (f == 6'h2A) return 4'd8;
        if (f == MFHI || f == MFLO) return 4'd10;
        if (f == MULTU || f == DIVU) return 4'd11;
        return 4'd9;
    endfunction

    task automatic set_in(input bit w8, input bit v, input logic [3:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            b8.Valid = v; b8.ALUOp = op; b8.ALUFunction = f; b8.A = a[7:0]; b8.B = b[7:0];
        end else begin
            b32.Valid = v; b32.ALUOp = op; b32.ALUFunction = f; b32.A = a; b32.B = b;
        end
    endtask

    function automatic logic stall_of(input bit w8);
        return w8 ? b8.Stall : b32.Stall;
    endfunction

    function automatic logic [31:0] hilo_of(input bit w8);
        return w8 ? {24'b0, b8.HiLoOut} : b32.HiLoOut;
    endfunction

    // Issue one MULTU/DIVU, count stall cycles, then read HI and LO back.
    task automatic run_op(input bit w8, input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_valid, input string tag);
        logic [31:0] mask, am, bm, eh, el;
        logic [63:0] p;
        int w, cnt;
        bit done;
        w    = w8 ? 8 : 32;
        mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
        am   = a & mask;
        bm   = b & mask;
        if (!is_div) begin
            p = {32'b0, am} * {32'b0, bm};
            if (w8) begin el = {24'b0, p[7:0]}; eh = {24'b0, p[15:8]}; end
            else    begin el = p[31:0];         eh = p[63:32];         end
        end else if (bm == 0) begin
            el = mask; eh = am;
        end else begin
            el = am / bm; eh = am % bm;
        end
        @(negedge clk);
        set_in(w8, 1'b1, 4'hF, is_div ? DIVU : MULTU, am, bm);
        @(posedge clk);
        cnt  = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stall_of(w8)) begin
                cnt++;
                if (hold_valid) set_in(w8, 1'b1, 4'hF, DIVU, ~am, bm + 32'd1);
                else            set_in(w8, 1'b0, 4'hF, 6'h20, 32'd0, 32'd0);
            end else begin
                done = 1;
            end
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall_cycles"}, 64'(cnt), 64'(w));
        set_in(w8, 1'b0, 4'hF, MFHI, 32'd0, 32'd0);
        #1 check({tag, "_hi"}, 64'(hilo_of(w8)), 64'(eh));
        set_in(w8, 1'b0, 4'hF, MFLO, 32'd0, 32'd0);
        #1 check({tag, "_lo"}, 64'(hilo_of(w8)), 64'(el));
    endtask

    initial begin
        logic [3:0]  op;
        logic [5:0]  f;
        logic [31:0] ra, rb;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 4'h0, 6'h0, 32'd0, 32'd0);
        set_in(1'b1, 1'b0, 4'h0, 6'h0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_stall32", 64'(b32.Stall), 64'd0);
        check("rst_stall8", 64'(b8.Stall), 64'd0);
        check("rst_hilo_none", 64'(b32.HiLoOut), 64'd0);
        set_in(1'b0, 1'b0, 4'hF, MFHI, 32'd0, 32'd0);
        #1 check("rst_mfhi", 64'(b32.HiLoOut), 64'd0);
        set_in(1'b0, 1'b0, 4'hF, MFLO, 32'd0, 32'd0);
        #1 check("rst_mflo", 64'(b32.HiLoOut), 64'd0);

        for (int i = 0; i < 16; i++) begin
            op = 4'(i);
            f  = 6'($urandom_range(0, 63));
            set_in(1'b0, 1'b0, op, f, 32'd0, 32'd0);
            #1 check("dec_itype", 64'(b32.ALUOperation), 64'(ref_aluop(op, f)));
        end
        for (int i = 0; i < 64; i++) begin
            f = 6'(i);
            set_in(1'b0, 1'b0, 4'hF, f, 32'd0, 32'd0);
            #1 check("dec_rtype", 64'(b32.ALUOperation), 64'(ref_aluop(4'hF, f)));
        end
        set_in(1'b0, 1'b0, 4'hF, 6'h3F, 32'd0, 32'd0);
        #1 check("dec_funct3f", 64'(b32.ALUOperation), 64'd9);

        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, "mul_max_x2");
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, "div_100_7_held");
        run_op(1'b0, 1'b1, 32'h1234, 32'd0, 1'b0, "div_by_zero");

        // Abandon a MULTU ten cycles into its stall.
        @(negedge clk);
        set_in(1'b0, 1'b1, 4'hF, MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 1'b0, 4'hF, 6'h20, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        check("busy_before_reset", 64'(b32.Stall), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_stall", 64'(b32.Stall), 64'd0);
        set_in(1'b0, 1'b0, 4'hF, MFHI, 32'd0, 32'd0);
        #1 check("mid_reset_hi", 64'(b32.HiLoOut), 64'd0);
        set_in(1'b0, 1'b0, 4'hF, MFLO, 32'd0, 32'd0);
        #1 check("mid_reset_lo", 64'(b32.HiLoOut), 64'd0);
        run_op(1'b0, 1'b0, 32'd3, 32'd5, 1'b0, "mul_3x5");

        // Reset and a launch on the same edge: reset must win.
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b0, 1'b1, 4'hF, MULTU, 32'd7, 32'd9);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b0, 1'b0, 4'hF, 6'h20, 32'd0, 32'd0);
        check("reset_beats_launch", 64'(b32.Stall), 64'd0);
        @(negedge clk);
        check("reset_beats_launch_2", 64'(b32.Stall), 64'd0);

        run_op(1'b1, 1'b0, 32'hFF, 32'hFF, 1'b0, "w8_mul_ff_ff");

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(1'b0, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), "rand32");
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(1'b1, 1'($urandom_range(0, 1)), ra, rb, 1'b0, "rand8");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
